// File: rtl/nettlp_pkg.sv
// NetTLP shared definitions: header qword layouts (big-endian view), protocol constants,
// receive-side metadata and a byte-swap helper.
package nettlp_pkg;

    localparam int          NETTLP_HDR_QWORDS = 6;
    localparam logic [15:0] ETH_P_IP          = 16'h0800;
    localparam logic [7:0]  IPPROTO_UDP       = 8'h11;

    // Wire bytes 0..7: destination MAC, first two bytes of source MAC
    typedef struct packed {
        logic [47:0] h_dest;
        logic [15:0] h_source_hi;
    } PACKET_QWORD0;

    // Wire bytes 8..15: rest of source MAC, ethertype, IPv4 version/ihl, tos
    typedef struct packed {
        logic [31:0] h_source_lo;
        logic [15:0] h_proto;
        logic [3:0]  version;
        logic [3:0]  ihl;
        logic [7:0]  tos;
    } PACKET_QWORD1;

    // Wire bytes 16..23: tot_len, id, frag_off, ttl, protocol
    typedef struct packed {
        logic [15:0] tot_len;
        logic [15:0] id;
        logic [15:0] frag_off;
        logic [7:0]  ttl;
        logic [7:0]  protocol;
    } PACKET_QWORD2;

    // Wire bytes 24..31: IP checksum, saddr, upper half of daddr
    typedef struct packed {
        logic [15:0] check;
        logic [31:0] saddr;
        logic [15:0] daddr0;
    } PACKET_QWORD3;

    // Wire bytes 32..39: lower half of daddr, UDP source/dest ports, UDP length
    typedef struct packed {
        logic [15:0] daddr1;
        logic [15:0] source;
        logic [15:0] dest;
        logic [15:0] len;
    } PACKET_QWORD4;

    // Wire bytes 40..47: UDP checksum, NetTLP seq (10 LSBs used), NetTLP timestamp
    typedef struct packed {
        logic [15:0] udp_check;
        logic [5:0]  seq_rsvd;
        logic [9:0]  seq;
        logic [31:0] tstamp;
    } PACKET_QWORD5;

    typedef struct packed {
        logic [9:0]  seq;
        logic [31:0] tstamp;
        logic [15:0] dport;
    } NETTLP_RX_META;

    // AXI-Stream carries wire byte 0 in [7:0]; headers are easier to read with byte 0 on top.
    function automatic logic [63:0] bswap64(input logic [63:0] d);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) begin
            r[8*i +: 8] = d[8*(7-i) +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/axis_reg_slice64.sv
// Single output register stage for the TLP stream: data, byte enables, framing and metadata
// move together and hold while the consumer stalls.
module axis_reg_slice64
    import nettlp_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_data,
    input  logic [DATA_W/8-1:0]   in_keep,
    input  logic                  in_last,
    input  logic                  in_user,
    input  logic                  in_sof,
    input  NETTLP_RX_META         in_meta,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic [DATA_W/8-1:0]   out_keep,
    output logic                  out_last,
    output logic                  out_user,
    output logic                  out_sof,
    output NETTLP_RX_META         out_meta
);

    logic                vld_p0;
    logic [DATA_W-1:0]   data_p0;
    logic [DATA_W/8-1:0] keep_p0;
    logic                last_p0;
    logic                user_p0;
    logic                sof_p0;
    NETTLP_RX_META       meta_p0;

    assign in_ready = !vld_p0 || out_ready;

    // Stage p0: load a new beat whenever the register is empty or being drained
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0  <= 1'b0;
            data_p0 <= '0;
            keep_p0 <= '0;
            last_p0 <= 1'b0;
            user_p0 <= 1'b0;
            sof_p0  <= 1'b0;
            meta_p0 <= '0;
        end else if (in_ready) begin
            vld_p0 <= in_valid;
            if (in_valid) begin
                data_p0 <= in_data;
                keep_p0 <= in_keep;
                last_p0 <= in_last;
                user_p0 <= in_user;
                sof_p0  <= in_sof;
                meta_p0 <= in_meta;
            end
        end
    end

    assign out_valid = vld_p0;
    assign out_data  = data_p0;
    assign out_keep  = keep_p0;
    assign out_last  = last_p0;
    assign out_user  = user_p0;
    assign out_sof   = sof_p0;
    assign out_meta  = meta_p0;

endmodule

// File: rtl/nettlp_rx_decap.sv
// NetTLP receive decapsulator: validates the 48-byte Eth/IPv4/UDP/NetTLP header, strips it,
// and forwards the TLP payload with seq/timestamp/port metadata. Bad or runt frames are dropped.
module nettlp_rx_decap
    import nettlp_pkg::*;
#(
    parameter logic [31:0] LOCAL_IP  = 32'hC0A8_0A01,
    parameter logic [15:0] PORT_BASE = 16'h3000,
    parameter logic [15:0] PORT_MASK = 16'hFFF0
) (
    input  logic        clk156,
    input  logic        sys_rst,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic [63:0] s_axis_tdata,
    input  logic [7:0]  s_axis_tkeep,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tuser,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic [63:0] m_axis_tdata,
    output logic [7:0]  m_axis_tkeep,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    output logic        m_sof,
    output logic [9:0]  m_seq,
    output logic [31:0] m_tstamp,
    output logic [15:0] m_dport,
    output logic [31:0] stat_rx_ok,
    output logic [31:0] stat_rx_drop
);

    typedef enum logic [1:0] {ST_HDR, ST_PAYLOAD, ST_DROP} state_t;

    localparam logic [2:0] LAST_HDR_QW = 3'(NETTLP_HDR_QWORDS - 1);

    state_t        state, state_nxt;
    logic [2:0]    qcnt, qcnt_nxt;
    logic          bad, bad_nxt, bad_acc;
    logic          sof_pend, sof_nxt;
    NETTLP_RX_META meta_r, meta_nxt;
    logic          ok_inc, drop_inc;

    logic [63:0]   be;
    PACKET_QWORD1  q1;
    PACKET_QWORD2  q2;
    PACKET_QWORD3  q3;
    PACKET_QWORD4  q4;
    PACKET_QWORD5  q5;
    logic          hdr_bad;
    logic          unused_hdr;

    logic          slice_in_valid;
    logic          slice_in_ready;
    NETTLP_RX_META out_meta;

    // Decode the current beat as header qword number qcnt and flag any field that disagrees
    always_comb begin
        be      = bswap64(s_axis_tdata);
        q1      = be;
        q2      = be;
        q3      = be;
        q4      = be;
        q5      = be;
        hdr_bad = 1'b0;
        case (qcnt)
            3'd1:    hdr_bad = (q1.h_proto != ETH_P_IP) || (q1.version != 4'd4) || (q1.ihl != 4'd5);
            3'd2:    hdr_bad = (q2.protocol != IPPROTO_UDP);
            3'd3:    hdr_bad = (q3.daddr0 != LOCAL_IP[31:16]);
            3'd4:    hdr_bad = (q4.daddr1 != LOCAL_IP[15:0]) || ((q4.dest & PORT_MASK) != PORT_BASE);
            default: hdr_bad = 1'b0;
        endcase
    end

    // Fields that are parsed but deliberately not checked (MACs, checksums, lengths)
    assign unused_hdr = ^{q1, q2, q3, q4, q5};

    // Frame state machine: header walk, payload pass-through, or discard until tlast
    always_comb begin
        state_nxt      = state;
        qcnt_nxt       = qcnt;
        bad_nxt        = bad;
        bad_acc        = bad;
        sof_nxt        = sof_pend;
        meta_nxt       = meta_r;
        ok_inc         = 1'b0;
        drop_inc       = 1'b0;
        s_axis_tready  = 1'b0;
        slice_in_valid = 1'b0;
        case (state)
            ST_HDR: begin
                s_axis_tready = 1'b1;
                if (s_axis_tvalid) begin
                    bad_acc = bad | hdr_bad;
                    if (qcnt == 3'd4) begin
                        meta_nxt.dport = q4.dest;
                    end
                    if (qcnt == LAST_HDR_QW) begin
                        meta_nxt.seq    = q5.seq;
                        meta_nxt.tstamp = q5.tstamp;
                    end
                    if (s_axis_tlast) begin
                        // Frame ended inside the header: nothing to forward
                        drop_inc = 1'b1;
                        qcnt_nxt = 3'd0;
                        bad_nxt  = 1'b0;
                    end else if (qcnt == LAST_HDR_QW) begin
                        qcnt_nxt  = 3'd0;
                        bad_nxt   = 1'b0;
                        sof_nxt   = 1'b1;
                        state_nxt = bad_acc ? ST_DROP : ST_PAYLOAD;
                    end else begin
                        qcnt_nxt = qcnt + 3'd1;
                        bad_nxt  = bad_acc;
                    end
                end
            end
            ST_PAYLOAD: begin
                s_axis_tready  = slice_in_ready;
                slice_in_valid = s_axis_tvalid;
                if (s_axis_tvalid && slice_in_ready) begin
                    sof_nxt = 1'b0;
                    if (s_axis_tlast) begin
                        ok_inc    = 1'b1;
                        state_nxt = ST_HDR;
                    end
                end
            end
            ST_DROP: begin
                s_axis_tready = 1'b1;
                if (s_axis_tvalid && s_axis_tlast) begin
                    drop_inc  = 1'b1;
                    state_nxt = ST_HDR;
                end
            end
            default: begin
                state_nxt = ST_HDR;
            end
        endcase
    end

    // Control state, latched metadata and frame statistics
    always_ff @(posedge clk156) begin
        if (sys_rst) begin
            state        <= ST_HDR;
            qcnt         <= 3'd0;
            bad          <= 1'b0;
            sof_pend     <= 1'b0;
            meta_r       <= '0;
            stat_rx_ok   <= 32'd0;
            stat_rx_drop <= 32'd0;
        end else begin
            state    <= state_nxt;
            qcnt     <= qcnt_nxt;
            bad      <= bad_nxt;
            sof_pend <= sof_nxt;
            meta_r   <= meta_nxt;
            if (ok_inc) begin
                stat_rx_ok <= stat_rx_ok + 32'd1;
            end
            if (drop_inc) begin
                stat_rx_drop <= stat_rx_drop + 32'd1;
            end
        end
    end

    axis_reg_slice64 #(
        .DATA_W (64)
    ) u_out_slice (
        .clk       (clk156),
        .rst       (sys_rst),
        .in_valid  (slice_in_valid),
        .in_ready  (slice_in_ready),
        .in_data   (s_axis_tdata),
        .in_keep   (s_axis_tkeep),
        .in_last   (s_axis_tlast),
        .in_user   (s_axis_tuser & s_axis_tlast),
        .in_sof    (sof_pend),
        .in_meta   (meta_r),
        .out_valid (m_axis_tvalid),
        .out_ready (m_axis_tready),
        .out_data  (m_axis_tdata),
        .out_keep  (m_axis_tkeep),
        .out_last  (m_axis_tlast),
        .out_user  (m_axis_tuser),
        .out_sof   (m_sof),
        .out_meta  (out_meta)
    );

    assign m_seq    = out_meta.seq;
    assign m_tstamp = out_meta.tstamp;
    assign m_dport  = out_meta.dport;

endmodule

// File: tb/tb_nettlp_rx_decap.sv
// Directed bench for nettlp_rx_decap: frames are built byte-by-byte from wire offsets, expected
// TLP beats are queued as they are driven and compared as the DUT emits them.
module tb_nettlp_rx_decap;

    logic        clk156 = 1'b0;
    logic        sys_rst;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [63:0] s_axis_tdata;
    logic [7:0]  s_axis_tkeep;
    logic        s_axis_tlast;
    logic        s_axis_tuser;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [63:0] m_axis_tdata;
    logic [7:0]  m_axis_tkeep;
    logic        m_axis_tlast;
    logic        m_axis_tuser;
    logic        m_sof;
    logic [9:0]  m_seq;
    logic [31:0] m_tstamp;
    logic [15:0] m_dport;
    logic [31:0] stat_rx_ok;
    logic [31:0] stat_rx_drop;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic        user;
        logic        sof;
        logic [9:0]  seq;
        logic [31:0] tstamp;
        logic [15:0] dport;
    } exp_beat_t;

    exp_beat_t   exp_q[$];
    int          tests = 0;
    int          fails = 0;
    int          exp_ok = 0;
    int          exp_drop = 0;
    bit          toggle_en = 1'b0;
    bit          chk_hold = 1'b0;
    logic        prev_stall = 1'b0;
    logic [63:0] prev_data = '0;
    logic [7:0]  prev_keep = '0;

    nettlp_rx_decap dut (
        .clk156        (clk156),
        .sys_rst       (sys_rst),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .m_sof         (m_sof),
        .m_seq         (m_seq),
        .m_tstamp      (m_tstamp),
        .m_dport       (m_dport),
        .stat_rx_ok    (stat_rx_ok),
        .stat_rx_drop  (stat_rx_drop)
    );

    always #5 clk156 = ~clk156;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitor: scoreboard compare on each transfer, plus hold checks while stalled
    always @(negedge clk156) begin
        if (m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) begin
                check("spurious_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
            end else begin
                check("tdata", m_axis_tdata, exp_q[0].data);
                check("tkeep", {56'd0, m_axis_tkeep}, {56'd0, exp_q[0].keep});
                check("tlast", {63'd0, m_axis_tlast}, {63'd0, exp_q[0].last});
                check("tuser", {63'd0, m_axis_tuser}, {63'd0, exp_q[0].user});
                check("sof", {63'd0, m_sof}, {63'd0, exp_q[0].sof});
                if (exp_q[0].sof) begin
                    check("seq", {54'd0, m_seq}, {54'd0, exp_q[0].seq});
                    check("tstamp", {32'd0, m_tstamp}, {32'd0, exp_q[0].tstamp});
                    check("dport", {48'd0, m_dport}, {48'd0, exp_q[0].dport});
                end
                void'(exp_q.pop_front());
            end
        end
        if (prev_stall) begin
            check("hold_valid", {63'd0, m_axis_tvalid}, 64'd1);
            check("hold_data", m_axis_tdata, prev_data);
            check("hold_keep", {56'd0, m_axis_tkeep}, {56'd0, prev_keep});
        end
        if (chk_hold && m_axis_tvalid && !m_axis_tready && !m_axis_tlast) begin
            check("s_tready_while_held", {63'd0, s_axis_tready}, 64'd0);
        end
        prev_stall <= m_axis_tvalid && !m_axis_tready && !sys_rst;
        prev_data  <= m_axis_tdata;
        prev_keep  <= m_axis_tkeep;
    end

    // Downstream ready toggler, active only during the back-pressure test
    initial begin
        forever begin
            @(posedge clk156);
            #2;
            if (toggle_en) m_axis_tready = ~m_axis_tready;
        end
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_beat(input logic [63:0] d, input logic [7:0] k, input logic l, input logic u);
        int n;
        n = 0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        s_axis_tuser  = u;
        @(negedge clk156);
        while (!s_axis_tready && n < 200) begin
            @(negedge clk156);
            n++;
        end
        if (n >= 200) check("s_tready_timeout", {63'd0, s_axis_tready}, 64'd1);
        @(posedge clk156);
        #1;
    endtask

    task automatic check_all_zero();
        check("rst_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
        check("rst_tdata", m_axis_tdata, 64'd0);
        check("rst_tkeep", {56'd0, m_axis_tkeep}, 64'd0);
        check("rst_tlast", {63'd0, m_axis_tlast}, 64'd0);
        check("rst_tuser", {63'd0, m_axis_tuser}, 64'd0);
        check("rst_sof", {63'd0, m_sof}, 64'd0);
        check("rst_meta", {m_seq, m_tstamp, m_dport}, 64'd0);
        check("rst_stat_ok", {32'd0, stat_rx_ok}, 64'd0);
        check("rst_stat_drop", {32'd0, stat_rx_drop}, 64'd0);
    endtask

    // Build and send one frame. runt_at: header qword carrying tlast (-1 none).
    // rst_at: payload beat index during which reset is asserted (-1 none).
    task automatic send_frame(input logic [15:0] proto, input logic [7:0] ipproto,
                              input logic [31:0] daddr, input logic [15:0] dport,
                              input logic [9:0] seq, input logic [31:0] ts, input int npay,
                              input logic [7:0] last_keep, input logic last_user,
                              input bit fwd, input int runt_at, input int rst_at);
        logic [7:0]  hb [48];
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
        logic        u;
        exp_beat_t   e;
        for (int i = 0; i < 48; i++) hb[i] = 8'(i * 7 + 1);
        hb[12] = proto[15:8];  hb[13] = proto[7:0];
        hb[14] = 8'h45;
        hb[23] = ipproto;
        hb[30] = daddr[31:24]; hb[31] = daddr[23:16]; hb[32] = daddr[15:8]; hb[33] = daddr[7:0];
        hb[36] = dport[15:8];  hb[37] = dport[7:0];
        hb[42] = {6'd0, seq[9:8]}; hb[43] = seq[7:0];
        hb[44] = ts[31:24]; hb[45] = ts[23:16]; hb[46] = ts[15:8]; hb[47] = ts[7:0];
        for (int q = 0; q < 6; q++) begin
            for (int b = 0; b < 8; b++) d[8*b +: 8] = hb[8*q + b];
            drive_beat(d, 8'hFF, (q == runt_at), 1'b0);
            if (q == runt_at) begin
                s_axis_tvalid = 1'b0;
                exp_drop++;
                return;
            end
        end
        for (int p = 0; p < npay; p++) begin
            d = {$urandom, $urandom};
            l = (p == npay - 1);
            k = l ? last_keep : 8'hFF;
            u = l ? last_user : 1'b0;
            if (p == rst_at) begin
                sys_rst       = 1'b1;
                s_axis_tvalid = 1'b1;
                s_axis_tdata  = d;
                s_axis_tkeep  = k;
                s_axis_tlast  = l;
                s_axis_tuser  = u;
                @(posedge clk156);
                #1;
                s_axis_tvalid = 1'b0;
                @(negedge clk156);
                check_all_zero();
                sys_rst  = 1'b0;
                exp_ok   = 0;
                exp_drop = 0;
                return;
            end
            if (fwd) begin
                e.data = d; e.keep = k; e.last = l; e.user = u; e.sof = (p == 0);
                e.seq = seq; e.tstamp = ts; e.dport = dport;
                exp_q.push_back(e);
            end
            drive_beat(d, k, l, u);
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        if (fwd) exp_ok++;
        else exp_drop++;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk156);
            n++;
        end
        check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
        repeat (3) @(posedge clk156);
        #1;
    endtask

    task automatic check_stats(input string tag);
        check({tag, "_stat_ok"}, {32'd0, stat_rx_ok}, 64'(exp_ok));
        check({tag, "_stat_drop"}, {32'd0, stat_rx_drop}, 64'(exp_drop));
    endtask

    initial begin
        sys_rst       = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
        m_axis_tready = 1'b1;
        repeat (4) @(posedge clk156);
        @(negedge clk156);
        check_all_zero();
        check("rst_s_tready", {63'd0, s_axis_tready}, 64'd1);
        sys_rst = 1'b0;
        @(posedge clk156);
        #1;

        // Valid frame, 3 TLP qwords
        send_frame(16'h0800, 8'h11, 32'hC0A8_0A01, 16'h3003, 10'h2A, 32'h1234_5678,
                   3, 8'hFF, 1'b0, 1'b1, -1, -1);
        wait_drain();
        check_stats("valid");

        // Four header rejections
        send_frame(16'h86DD, 8'h11, 32'hC0A8_0A01, 16'h3003, 10'h001, 32'h1, 2, 8'hFF, 1'b0, 1'b0, -1, -1);
        send_frame(16'h0800, 8'h06, 32'hC0A8_0A01, 16'h3003, 10'h002, 32'h2, 2, 8'hFF, 1'b0, 1'b0, -1, -1);
        send_frame(16'h0800, 8'h11, 32'hC0A8_0A02, 16'h3003, 10'h003, 32'h3, 2, 8'hFF, 1'b0, 1'b0, -1, -1);
        send_frame(16'h0800, 8'h11, 32'hC0A8_0A01, 16'h4000, 10'h004, 32'h4, 2, 8'hFF, 1'b0, 1'b0, -1, -1);
        wait_drain();
        check_stats("bad_hdr");

        // Runt frame ending on header qword 3, then a clean frame
        send_frame(16'h0800, 8'h11, 32'hC0A8_0A01, 16'h3001, 10'h005, 32'h5, 0, 8'hFF, 1'b0, 1'b0, 3, -1);
        send_frame(16'h0800, 8'h11, 32'hC0A8_0A01, 16'h3001, 10'h3FF, 32'hCAFE_F00D,
                   2, 8'hFF, 1'b0, 1'b1, -1, -1);
        wait_drain();
        check_stats("runt");

        // Back-pressure: downstream ready toggling over a 16-qword payload, top of port window
        chk_hold  = 1'b1;
        toggle_en = 1'b1;
        send_frame(16'h0800, 8'h11, 32'hC0A8_0A01, 16'h300F, 10'h155, 32'hDEAD_BEEF,
                   16, 8'hFF, 1'b0, 1'b1, -1, -1);
        wait_drain();
        toggle_en = 1'b0;
        chk_hold  = 1'b0;
        m_axis_tready = 1'b1;
        @(posedge clk156);
        #1;
        check_stats("stall");

        // Partial last beat carrying a frame error
        send_frame(16'h0800, 8'h11, 32'hC0A8_0A01, 16'h3008, 10'h0C3, 32'h0BAD_0001,
                   4, 8'h0F, 1'b1, 1'b1, -1, -1);
        wait_drain();
        check_stats("tuser");

        // Reset during payload beat 2, then a clean frame
        send_frame(16'h0800, 8'h11, 32'hC0A8_0A01, 16'h3002, 10'h111, 32'h0000_0042,
                   6, 8'hFF, 1'b0, 1'b1, -1, 2);
        wait_drain();
        send_frame(16'h0800, 8'h11, 32'hC0A8_0A01, 16'h3004, 10'h222, 32'h7777_0000,
                   3, 8'h3F, 1'b0, 1'b1, -1, -1);
        wait_drain();
        check_stats("post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
